// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM states and divisor limits for the clock-divider controller
package clk_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} div_state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_upd_hs.sv
// clk_div_upd_hs: pending-divisor register with valid/ready handshake and err/done pulses
module clk_div_upd_hs
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    input  logic             apply_ok,
    output logic             div_ready,
    output logic             div_err,
    output logic             div_done,
    output logic             load,
    output logic [CNT_W-1:0] pend_div
);

    logic pend_valid;
    logic accept;
    logic bad;

    assign div_ready = !pend_valid;
    assign accept    = div_req && div_ready;
    assign bad       = div_val < CNT_W'(MIN_DIV);
    assign load      = pend_valid && apply_ok;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_div   <= '0;
            div_err    <= 1'b0;
            div_done   <= 1'b0;
        end else begin
            pend_valid <= pend_valid ? !apply_ok : (accept && !bad);
            pend_div   <= accept ? div_val : pend_div;
            div_err    <= accept && bad;
            div_done   <= load;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable integer clock divider with period-aligned divisor updates
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ready,
    output logic             div_done,
    output logic             div_err,
    output logic [CNT_W-1:0] cur_div,
    output logic [CNT_W-1:0] phase,
    output logic             tick,
    output logic             clk_out,
    output logic             busy
);

    div_state_t       state, state_n;
    logic [CNT_W-1:0] phase_n;
    logic [CNT_W-1:0] cur_div_n;
    logic [CNT_W-1:0] pend_div;
    logic             wrap;
    logic             load;

    assign busy = state != IDLE;
    assign wrap = busy && (phase == cur_div - CNT_W'(1));
    assign tick = wrap;

    clk_div_upd_hs #(.CNT_W(CNT_W)) u_hs (
        .clk_in    (clk_in),
        .rst       (rst),
        .div_req   (div_req),
        .div_val   (div_val),
        .apply_ok  (!busy || wrap),
        .div_ready (div_ready),
        .div_err   (div_err),
        .div_done  (div_done),
        .load      (load),
        .pend_div  (pend_div)
    );

    always_comb begin
        state_n   = en ? RUN : ((busy && !wrap) ? DRAIN : IDLE);
        phase_n   = (busy && !wrap) ? phase + CNT_W'(1) : '0;
        cur_div_n = load ? pend_div : cur_div;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= '0;
            cur_div <= CNT_W'(DEF_DIV);
            clk_out <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            cur_div <= cur_div_n;
            clk_out <= (state_n != IDLE) && (phase_n < (cur_div_n >> 1));
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and randomized checks of clk_div_ctrl against a behavioural model
module tb_clk_div_ctrl;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 3;

    logic             clk_in;
    logic             rst;
    logic             en;
    logic             div_req;
    logic [CNT_W-1:0] div_val;
    logic             div_ready;
    logic             div_done;
    logic             div_err;
    logic [CNT_W-1:0] cur_div;
    logic [CNT_W-1:0] phase;
    logic             tick;
    logic             clk_out;
    logic             busy;

    int checks = 0;
    int errs   = 0;
    bit chk_on = 0;

    int m_pos;
    int m_div;
    bit m_active;
    bit m_err;
    bit m_done;
    bit m_acc;
    int pend[$];

    clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .div_req   (div_req),
        .div_val   (div_val),
        .div_ready (div_ready),
        .div_done  (div_done),
        .div_err   (div_err),
        .cur_div   (cur_div),
        .phase     (phase),
        .tick      (tick),
        .clk_out   (clk_out),
        .busy      (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        bit last;
        bit apply;
        if (rst) begin
            m_active = 0;
            m_pos    = 0;
            m_div    = DEF_DIV;
            m_err    = 0;
            m_done   = 0;
            m_acc    = 0;
            pend.delete();
        end else begin
            last   = m_active && m_pos == m_div - 1;
            apply  = pend.size() != 0 && (!m_active || last);
            m_acc  = div_req && pend.size() == 0;
            m_err  = m_acc && div_val < 2;
            m_done = apply;
            if (apply) m_div = pend.pop_front();
            if (m_acc && div_val >= 2) pend.push_back(int'(div_val));
            if (m_active) begin
                m_active = en || !last;
                m_pos    = last ? 0 : m_pos + 1;
            end else begin
                m_active = en;
                m_pos    = 0;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            chk("m_phase", phase, m_pos);
            chk("m_cur_div", cur_div, m_div);
            chk("m_busy", busy, m_active);
            chk("m_tick", tick, m_active && m_pos == m_div - 1);
            chk("m_clk_out", clk_out, m_active && m_pos < m_div / 2);
            chk("m_div_ready", div_ready, pend.size() == 0);
            chk("m_div_err", div_err, m_err);
            chk("m_div_done", div_done, m_done);
        end
    end

    initial begin
        int r;
        rst = 1; en = 0; div_req = 0; div_val = '0;
        @(negedge clk_in);
        chk_on = 1;
        @(negedge clk_in);
        rst = 0;
        @(negedge clk_in);
        chk("rst_cur_div", cur_div, 3);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", div_ready, 1);
        en = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_in);
            chk("n3_phase", phase, i % 3);
            chk("n3_tick", tick, (i % 3) == 2);
            chk("n3_clk_out", clk_out, (i % 3) == 0);
        end
        @(negedge clk_in);
        div_req = 1; div_val = 8'd4;
        @(negedge clk_in);
        chk("upd_ready_lo1", div_ready, 0);
        div_req = 0;
        @(negedge clk_in);
        chk("upd_ready_lo2", div_ready, 0);
        chk("upd_old_div", cur_div, 3);
        @(negedge clk_in);
        chk("upd_done", div_done, 1);
        chk("upd_cur_div", cur_div, 4);
        chk("upd_ready_hi", div_ready, 1);
        chk("upd_phase0", phase, 0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk_in);
            chk("n4_clk_out", clk_out, (i % 4) < 2);
            chk("n4_phase", phase, i % 4);
        end
        div_req = 1; div_val = 8'd1;
        @(negedge clk_in);
        chk("err_pulse", div_err, 1);
        chk("err_cur_div", cur_div, 4);
        chk("err_ready", div_ready, 1);
        chk("err_phase", phase, 0);
        div_req = 0;
        @(negedge clk_in);
        chk("err_clear", div_err, 0);
        chk("err_phase1", phase, 1);
        en = 0;
        @(negedge clk_in);
        chk("drain_p2", phase, 2);
        chk("drain_busy", busy, 1);
        @(negedge clk_in);
        chk("drain_p3", phase, 3);
        chk("drain_tick", tick, 1);
        @(negedge clk_in);
        chk("drain_idle", busy, 0);
        chk("drain_clk_out", clk_out, 0);
        en = 1;
        @(negedge clk_in);
        chk("rerun_p0", phase, 0);
        @(negedge clk_in);
        en = 0;
        @(negedge clk_in);
        chk("redrain_p2", phase, 2);
        en = 1;
        @(negedge clk_in);
        chk("resume_p3", phase, 3);
        @(negedge clk_in);
        chk("resume_p0", phase, 0);
        chk("resume_busy", busy, 1);
        div_req = 1; div_val = 8'd7;
        @(negedge clk_in);
        chk("pend_ready", div_ready, 0);
        div_req = 0; rst = 1;
        @(negedge clk_in);
        chk("prst_cur_div", cur_div, 3);
        chk("prst_ready", div_ready, 1);
        chk("prst_busy", busy, 0);
        rst = 0;
        @(negedge clk_in);
        chk("prst_no_done", div_done, 0);
        chk("prst_div_kept", cur_div, 3);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) en = !en;
            if (div_req && m_acc) div_req = 0;
            if (!div_req && $urandom_range(0, 4) == 0) begin
                div_req = 1;
                r = $urandom_range(0, 19);
                div_val = r < 2 ? CNT_W'(r) : r < 18 ? CNT_W'(2 + r % 8) : r == 18 ? 8'd255 : 8'd16;
            end
        end
        rst = 0; div_req = 0;
        repeat (2) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
